// File: rtl/hex_operand_loader_if.sv
// Purpose: character-in / operand-out bundle between the UART rx path, the loader and the RSA core.
// Latency: none, wiring only.
// Backpressure: rx_ready throttles characters; out_ready accepts the held operand.
interface hex_operand_loader_if #(
    parameter int WIDTH = 32
);
    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = $clog2(DIGITS + 1);

    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic [WIDTH-1:0] operand;
    logic             operand_valid;
    logic             out_ready;
    logic [CW-1:0]    digit_count;
    logic             err;

    // Character source and operand consumer side.
    modport master (
        output rx_valid, rx_data, out_ready,
        input  rx_ready, operand, operand_valid, digit_count, err
    );

    // Loader side.
    modport slave (
        input  rx_valid, rx_data, out_ready,
        output rx_ready, operand, operand_valid, digit_count, err
    );
endinterface

// File: rtl/hex_operand_loader.sv
// Purpose: assemble a CR/LF-terminated ASCII hex line into a WIDTH-bit operand; bad lines pulse err.
// Latency: operand_valid or err rises on the edge after the accepted terminator.
// Backpressure: rx_ready is low only while an operand waits in HOLD for out_ready.
module hex_operand_loader #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hex_operand_loader_if.slave  bus
);
    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_operand;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_digit_count;
    logic             r_rx_ready;
    logic             r_operand_valid;
    logic             r_err;

    logic             w_xfer;
    logic             w_is_digit;
    logic             w_is_term;
    logic [3:0]       w_nibble;

    // Classify the incoming character and decode hex digits to a nibble.
    always_comb begin
        w_is_digit = 1'b0;
        w_is_term  = 1'b0;
        w_nibble   = 4'h0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            w_is_digit = 1'b1;
            w_nibble   = bus.rx_data[3:0];
        end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                     (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 0xA..0xF.
            w_is_digit = 1'b1;
            w_nibble   = bus.rx_data[3:0] + 4'd9;
        end else if (bus.rx_data == 8'h0D || bus.rx_data == 8'h0A) begin
            w_is_term  = 1'b1;
        end
    end

    assign w_xfer = bus.rx_valid && r_rx_ready;

    // Line framing FSM; every output is a register so the core sees glitch-free signals.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_acc           <= '0;
            r_count         <= '0;
            r_operand       <= '0;
            r_digit_count   <= '0;
            r_operand_valid <= 1'b0;
            r_rx_ready      <= 1'b1;
            r_err           <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Bare terminators (empty line, LF of CR-LF) are swallowed here.
                    if (w_xfer) begin
                        if (w_is_digit) begin
                            r_acc   <= {{(WIDTH-4){1'b0}}, w_nibble};
                            r_count <= CW'(1);
                            r_state <= S_COLLECT;
                        end else if (!w_is_term) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_xfer) begin
                        if (w_is_digit) begin
                            if (r_count == CW'(DIGITS)) begin
                                // One digit too many: the whole line is rejected.
                                r_state <= S_DRAIN;
                            end else begin
                                r_acc   <= {r_acc[WIDTH-5:0], w_nibble};
                                r_count <= r_count + CW'(1);
                            end
                        end else if (w_is_term) begin
                            r_operand       <= r_acc;
                            r_digit_count   <= r_count;
                            r_operand_valid <= 1'b1;
                            r_rx_ready      <= 1'b0;
                            r_state         <= S_HOLD;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_xfer && w_is_term) begin
                        r_err   <= 1'b1;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    // operand/digit_count stay put after the handshake until the next good line.
                    if (bus.out_ready) begin
                        r_operand_valid <= 1'b0;
                        r_acc           <= '0;
                        r_count         <= '0;
                        r_rx_ready      <= 1'b1;
                        r_state         <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready      = r_rx_ready;
    assign bus.operand       = r_operand;
    assign bus.operand_valid = r_operand_valid;
    assign bus.digit_count   = r_digit_count;
    assign bus.err           = r_err;

endmodule

// File: tb/tb_hex_operand_loader.sv
// Purpose: directed and random character streams against a line-level reference model.
// Latency: every cycle's outputs are compared one step after the rising edge.
// Backpressure: the driver retries a character until the model says it was accepted.
module tb_hex_operand_loader;
    localparam int WIDTH  = 32;
    localparam int DIGITS = WIDTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hex_operand_loader_if #(.WIDTH(WIDTH)) bus ();

    hex_operand_loader #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: characters of the current line, and what the outputs should be.
    logic [3:0]  m_dig[$];
    bit          m_bad;
    bit          m_hold;
    bit          exp_err;
    logic [31:0] m_op;
    int          m_cnt;

    string hx_lo = "0123456789abcdef";
    string hx_up = "0123456789ABCDEF";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_dig.delete();
        m_bad   = 1'b0;
        m_hold  = 1'b0;
        exp_err = 1'b0;
        m_op    = '0;
        m_cnt   = 0;
    endtask

    // 0 = hex digit, 1 = terminator, 2 = anything else
    function automatic int classify(input logic [7:0] c, output logic [3:0] v);
        v = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (c == hx_lo[i] || c == hx_up[i]) begin
                v = 4'(i);
                return 0;
            end
        end
        if (c == 8'h0D || c == 8'h0A) return 1;
        return 2;
    endfunction

    // Line-level evaluation: a line is judged as a whole when its terminator arrives.
    task automatic model_char(input logic [7:0] c);
        logic [3:0]  n;
        int          kind;
        logic [63:0] val;
        kind = classify(c, n);
        if (kind == 1) begin
            if (m_bad || m_dig.size() > DIGITS) begin
                exp_err = 1'b1;
            end else if (m_dig.size() > 0) begin
                val = 0;
                foreach (m_dig[i]) val = val * 16 + 64'(m_dig[i]);
                m_op   = val[31:0];
                m_cnt  = m_dig.size();
                m_hold = 1'b1;
            end
            m_dig.delete();
            m_bad = 1'b0;
        end else if (kind == 0) begin
            m_dig.push_back(n);
        end else begin
            m_bad = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("rx_ready",      64'(bus.rx_ready),      64'(!m_hold));
        chk("operand_valid", 64'(bus.operand_valid), 64'(m_hold));
        chk("err",           64'(bus.err),           64'(exp_err));
        chk("operand",       64'(bus.operand),       64'(m_op));
        chk("digit_count",   64'(bus.digit_count),   64'(m_cnt));
    endtask

    // One clock: drive inputs, advance, update the model, compare everything.
    task automatic cyc(input bit v, input logic [7:0] d, input bit ordy, output bit took);
        bus.rx_valid  = v;
        bus.rx_data   = d;
        bus.out_ready = ordy;
        took = v && !m_hold;
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (took) begin
            model_char(d);
        end
        check_all();
    endtask

    task automatic idle(input bit ordy);
        bit t;
        cyc(1'b0, 8'h00, ordy, t);
    endtask

    task automatic send(input string s, input bit ordy);
        for (int i = 0; i < s.len(); i++) begin
            bit took;
            int tries;
            tries = 0;
            do begin
                cyc(1'b1, s[i], ordy, took);
                tries++;
            end while (!took && tries < 16);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          t;
        logic [7:0]  c;
        int          r;

        m_reset();
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.out_ready = 1'b0;
        @(posedge clk);
        do_reset();

        // Basic mixed-case line, consumer stalls then accepts.
        send("1a2B\r", 1'b0);
        chk("op_1a2b",  64'(bus.operand),     64'h1A2B);
        chk("cnt_1a2b", 64'(bus.digit_count), 64'd4);
        chk("hold_rdy", 64'(bus.rx_ready),    64'd0);
        idle(1'b0);
        idle(1'b1);
        chk("ov_drop",  64'(bus.operand_valid), 64'd0);
        chk("rdy_back", 64'(bus.rx_ready),      64'd1);

        // Full-width operand, CR-LF pair, then a one-digit line.
        send("deadbeef\r\n", 1'b1);
        chk("op_dead",  64'(bus.operand),     64'hDEADBEEF);
        chk("cnt_dead", 64'(bus.digit_count), 64'd8);
        send("7\n", 1'b1);
        chk("op_7",     64'(bus.operand),     64'h7);
        chk("cnt_7",    64'(bus.digit_count), 64'd1);
        idle(1'b1);

        // Nine digits overflow a 32-bit operand.
        send("123456789\r", 1'b0);
        chk("err_ovf",  64'(bus.err),           64'd1);
        chk("ov_ovf",   64'(bus.operand_valid), 64'd0);
        idle(1'b0);
        chk("err_once", 64'(bus.err),           64'd0);
        send("ff\r", 1'b1);
        chk("op_ff",    64'(bus.operand),       64'hFF);
        idle(1'b1);

        // Invalid characters mid-line, then lone terminators.
        send("12g4\r", 1'b0);
        chk("err_g",    64'(bus.err),     64'd1);
        send("1 2\r", 1'b0);
        chk("err_sp",   64'(bus.err),     64'd1);
        chk("op_keep",  64'(bus.operand), 64'hFF);
        send("\r\r", 1'b0);
        idle(1'b0);

        // Reset mid-line discards the partial operand.
        send("abc", 1'b0);
        do_reset();
        chk("rst_op",   64'(bus.operand),     64'd0);
        send("5\r", 1'b0);
        chk("op_5",     64'(bus.operand),     64'h5);
        chk("cnt_5",    64'(bus.digit_count), 64'd1);

        // A character offered during HOLD waits and becomes the next line's first digit.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h39, 1'b0, t);
        cyc(1'b1, 8'h39, 1'b1, t);
        cyc(1'b1, 8'h39, 1'b0, t);
        cyc(1'b1, 8'h0D, 1'b0, t);
        chk("op_9",     64'(bus.operand),       64'h9);
        chk("ov_9",     64'(bus.operand_valid), 64'd1);
        idle(1'b1);

        // Random character soup with random valid/ready and occasional reset.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 19);
            if (r < 10 || r >= 16) c = ($urandom_range(0, 1) != 0) ? hx_lo[$urandom_range(0, 15)]
                                                                   : hx_up[$urandom_range(0, 15)];
            else if (r < 12) c = 8'h0D;
            else if (r < 13) c = 8'h0A;
            else if (r < 14) c = 8'h20;
            else if (r < 15) c = 8'h67;
            else c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) do_reset();
            else cyc($urandom_range(0, 9) < 8, c, $urandom_range(0, 1) != 0, t);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
